// File: rtl/exe_alu_stage.sv
// Execute-stage ALU with NZCV status register and the EXE/MEM pipeline
// register. Flags are registered and fed back as carry-in for ADC/SBC.
module exe_alu_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [REG_W-1:0]  dest,
    output logic [3:0]        status
);
    localparam int MSB = DATA_W - 1;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] st_val_q, st_val_d;
    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic [3:0]        status_q, status_d;

    logic              cin;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] r;
    logic              c_new, v_new;
    logic              cmd_known;

    assign cin = status_q[1];

    // ALU: result plus C/V; logical ops keep the old C and V.
    always_comb begin
        wide      = '0;
        r         = '0;
        c_new     = status_q[1];
        v_new     = status_q[0];
        cmd_known = 1'b1;
        unique case (exe_cmd)
            4'b0001: r = val2;
            4'b1001: r = ~val2;
            4'b0010, 4'b0011: begin
                wide  = {1'b0, val1} + {1'b0, val2}
                      + {{DATA_W{1'b0}}, (exe_cmd == 4'b0011) & cin};
                r     = wide[MSB:0];
                c_new = wide[DATA_W];
                v_new = (val1[MSB] == val2[MSB]) && (r[MSB] != val1[MSB]);
            end
            4'b0100, 4'b0101: begin
                // Borrow into bit DATA_W means val1 < val2 + borrow.
                wide  = {1'b0, val1} - {1'b0, val2}
                      - {{DATA_W{1'b0}}, (exe_cmd == 4'b0101) & ~cin};
                r     = wide[MSB:0];
                c_new = ~wide[DATA_W];
                v_new = (val1[MSB] != val2[MSB]) && (r[MSB] != val1[MSB]);
            end
            4'b0110: r = val1 & val2;
            4'b0111: r = val1 | val2;
            4'b1000: r = val1 ^ val2;
            default: cmd_known = 1'b0;
        endcase
    end

    // Next state: freeze holds everything, bubbles clear valid and controls.
    always_comb begin
        valid_d    = valid_q;
        result_d   = result_q;
        st_val_d   = st_val_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        dest_d     = dest_q;
        status_d   = status_q;
        if (!freeze) begin
            if (flush || !valid_in) begin
                valid_d    = 1'b0;
                wb_en_d    = 1'b0;
                mem_r_en_d = 1'b0;
                mem_w_en_d = 1'b0;
            end else begin
                valid_d    = 1'b1;
                result_d   = r;
                st_val_d   = st_val_in;
                wb_en_d    = wb_en_in;
                mem_r_en_d = mem_r_en_in;
                mem_w_en_d = mem_w_en_in;
                dest_d     = dest_in;
                if (s_in && cmd_known)
                    status_d = {r[MSB], (r == '0), c_new, v_new};
            end
        end
    end

    // Pipeline and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            st_val_q   <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            dest_q     <= '0;
            status_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            st_val_q   <= st_val_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            dest_q     <= dest_d;
            status_q   <= status_d;
        end
    end

    assign valid_out  = valid_q;
    assign alu_result = result_q;
    assign st_val     = st_val_q;
    assign wb_en      = wb_en_q;
    assign mem_r_en   = mem_r_en_q;
    assign mem_w_en   = mem_w_en_q;
    assign dest       = dest_q;
    assign status     = status_q;
endmodule

// File: tb/tb_exe_alu_stage.sv
// Randomized bench for exe_alu_stage against an arithmetic reference model.
module tb_exe_alu_stage;
    logic        clk = 1'b0;
    logic        rst_n, freeze, flush, valid_in, s_in;
    logic [3:0]  exe_cmd;
    logic [31:0] val1, val2, st_val_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in;
    logic [3:0]  dest_in;
    logic        valid_out, wb_en, mem_r_en, mem_w_en;
    logic [31:0] alu_result, st_val;
    logic [3:0]  dest, status;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    bit        m_valid, m_wb, m_mr, m_mw;
    bit [31:0] m_res, m_st;
    bit [3:0]  m_dest, m_status;

    always #5 clk = ~clk;

    exe_alu_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .exe_cmd(exe_cmd), .s_in(s_in),
        .val1(val1), .val2(val2), .st_val_in(st_val_in),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .dest_in(dest_in), .valid_out(valid_out), .alu_result(alu_result),
        .st_val(st_val), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .dest(dest), .status(status)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Operation semantics from plain integer arithmetic on 64-bit values.
    function automatic void ref_alu(input bit [3:0] cmd, input bit [31:0] a, input bit [31:0] b,
                                    input bit [3:0] st, output bit [31:0] r,
                                    output bit [3:0] nst, output bit known);
        longint sa, sb, sres, ures;
        bit c, v, ci;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = st[1];
        c = st[1];
        v = st[0];
        known = 1'b1;
        r = 32'd0;
        case (cmd)
            4'h1: r = b;
            4'h9: r = ~b;
            4'h6: r = a & b;
            4'h7: r = a | b;
            4'h8: r = a ^ b;
            4'h2, 4'h3: begin
                ures = longint'(a) + longint'(b) + ((cmd == 4'h3 && ci) ? 1 : 0);
                sres = sa + sb + ((cmd == 4'h3 && ci) ? 1 : 0);
                r = ures[31:0];
                c = (ures >= 64'sh1_0000_0000);
                v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
            end
            4'h4, 4'h5: begin
                ures = longint'(a) - longint'(b) - ((cmd == 4'h5 && !ci) ? 1 : 0);
                sres = sa - sb - ((cmd == 4'h5 && !ci) ? 1 : 0);
                r = ures[31:0];
                c = (ures >= 0);
                v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
            end
            default: known = 1'b0;
        endcase
        nst = {r[31], r == 32'd0, c, v};
    endfunction

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit rst, input bit frz, input bit fl, input bit vin,
                        input bit [3:0] cmd, input bit s, input bit [31:0] a,
                        input bit [31:0] b, input bit [31:0] stv, input bit wb,
                        input bit mr, input bit mw, input bit [3:0] dst);
        bit [31:0] r;
        bit [3:0]  nst;
        bit known;
        @(negedge clk);
        rst_n = ~rst; freeze = frz; flush = fl; valid_in = vin; exe_cmd = cmd;
        s_in = s; val1 = a; val2 = b; st_val_in = stv;
        wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; dest_in = dst;
        ref_alu(cmd, a, b, m_status, r, nst, known);
        if (rst) begin
            m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
            m_res = 0; m_st = 0; m_dest = 0; m_status = 0;
        end else if (!frz) begin
            if (fl || !vin) begin
                m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
            end else begin
                m_valid = 1; m_res = r; m_st = stv; m_dest = dst;
                m_wb = wb; m_mr = mr; m_mw = mw;
                if (s && known) m_status = nst;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", valid_out, m_valid);
        chk("ctrl", {wb_en, mem_r_en, mem_w_en}, {m_wb, m_mr, m_mw});
        chk("status", status, m_status);
        if (m_valid || rst) begin
            chk("result", alu_result, m_res);
            chk("st_val", st_val, m_st);
            chk("dest", dest, m_dest);
        end
    endtask

    initial begin
        bit [31:0] a, b;
        // Reset held two cycles with a live ADDS presented.
        step(1, 0, 0, 1, 4'h2, 1, 32'hFFFF_FFFF, 32'd1, 32'h55, 1, 0, 1, 4'd3);
        step(1, 0, 0, 1, 4'h2, 1, 32'hFFFF_FFFF, 32'd1, 32'h55, 1, 0, 1, 4'd3);
        chk("rst_all", {valid_out, alu_result, st_val, wb_en, mem_r_en, mem_w_en, dest, status}, '0);

        // ADDS carry-out then ADC consuming it.
        step(0, 0, 0, 1, 4'h2, 1, 32'hFFFF_FFFF, 32'd1, 32'h0, 1, 0, 0, 4'd1);
        chk("adds_res", alu_result, 32'd0);
        chk("adds_st", status, 4'b0110);
        step(0, 0, 0, 1, 4'h3, 0, 32'd5, 32'd7, 32'h0, 1, 0, 0, 4'd2);
        chk("adc_res", alu_result, 32'd13);

        // SUBS overflow, SBC with C=1, then with C=0.
        step(0, 0, 0, 1, 4'h4, 1, 32'h8000_0000, 32'd1, 32'h0, 1, 0, 0, 4'd1);
        chk("subs_res", alu_result, 32'h7FFF_FFFF);
        chk("subs_st", status, 4'b0011);
        step(0, 0, 0, 1, 4'h5, 0, 32'd10, 32'd3, 32'h0, 1, 0, 0, 4'd1);
        chk("sbc_c1", alu_result, 32'd7);
        step(0, 0, 0, 1, 4'h4, 1, 32'd0, 32'd1, 32'h0, 0, 0, 0, 4'd0); // clears C
        step(0, 0, 0, 1, 4'h5, 0, 32'd10, 32'd3, 32'h0, 1, 0, 0, 4'd1);
        chk("sbc_c0", alu_result, 32'd6);

        // ANDS keeps C and V.
        step(0, 0, 0, 1, 4'h4, 1, 32'h8000_0000, 32'd1, 32'h0, 1, 0, 0, 4'd1);
        step(0, 0, 0, 1, 4'h6, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1, 0, 0, 4'd1);
        chk("ands_st", status, 4'b0111);

        // Freeze three cycles with changing inputs, then release.
        step(0, 1, 1, 1, 4'h2, 1, 32'd1, 32'd2, 32'h9, 1, 1, 1, 4'd9);
        step(0, 1, 0, 1, 4'h4, 1, 32'd3, 32'd3, 32'h8, 0, 1, 0, 4'd8);
        step(0, 1, 0, 1, 4'h1, 1, 32'd0, 32'd0, 32'h7, 1, 0, 1, 4'd7);
        chk("frz_hold", {alu_result, status}, {32'd0, 4'b0111});
        step(0, 0, 0, 1, 4'h2, 1, 32'd20, 32'd22, 32'h7, 1, 0, 1, 4'd7);
        chk("frz_rel", alu_result, 32'd42);
        step(0, 0, 0, 0, 4'h2, 1, 32'd20, 32'd22, 32'h7, 1, 0, 1, 4'd7);
        chk("once", valid_out, 1'b0);

        // Flushed CMPS leaves flags; unflushed sets Z,C.
        step(0, 0, 1, 1, 4'h4, 1, 32'd5, 32'd5, 32'h0, 1, 0, 1, 4'd2);
        chk("flush_st", status, 4'b0000);
        step(0, 0, 0, 1, 4'h4, 1, 32'd5, 32'd5, 32'h0, 0, 0, 0, 4'd2);
        chk("cmp_st", status, 4'b0110);

        // Reset wins over freeze.
        step(1, 1, 0, 1, 4'h2, 1, 32'd1, 32'd1, 32'h1, 1, 1, 1, 4'd1);
        chk("rst_frz", {valid_out, status}, 5'd0);

        // Random traffic across all codes, freezes, flushes and bubbles.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000 - $urandom_range(0, 2);
                1: a = 32'hFFFF_FFFF - $urandom_range(0, 2);
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) != 0),
                 4'($urandom_range(0, 15)), 1'($urandom), a, b, $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exe_alu_stage.md
# exe_alu_stage

Execute-stage ALU, NZCV status register and EXE/MEM pipeline register. Consumes the second operand produced by the Val2 generator in the execute stage, together with the decoded operation from the ID/EX register. Computes the result and condition flags, and registers the result plus memory and write-back controls toward the memory stage. The registered flags feed back to the decode stage's condition check and to the ALU carry-in.

## Interface
Parameters:
- `DATA_W`, 32, datapath width.
- `REG_W`, 4, register-index width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `freeze`  in  1  stall from memory stage; holds every register.
- `flush`  in  1  kills the instruction currently presented on the inputs.
- `valid_in`  in  1  ID/EX holds a real instruction.
- `exe_cmd`  in  4  ALU operation code.
- `s_in`  in  1  update NZCV.
- `val1`  in  DATA_W  Rn value.
- `val2`  in  DATA_W  shifted/rotated/immediate operand from Val2 generator.
- `st_val_in`  in  DATA_W  Rd value for stores.
- `wb_en_in`, `mem_r_en_in`, `mem_w_en_in`  in  1 each  controls forwarded to MEM.
- `dest_in`  in  REG_W  destination register.
- `valid_out`  out  1  EXE/MEM holds a real instruction.
- `alu_result`  out  DATA_W  registered result / memory address.
- `st_val`  out  DATA_W  registered store data.
- `wb_en`, `mem_r_en`, `mem_w_en`  out  1 each  registered controls; forced 0 when `valid_out`=0.
- `dest`  out  REG_W  registered destination.
- `status`  out  4  registered flags {N,Z,C,V}.

## Operation
Let `Cin` = `status[1]`. All arithmetic is done at DATA_W+1 bits; bit DATA_W is the carry.

`exe_cmd` encoding:
- 0001 MOV: r=val2.
- 1001 MVN: r=~val2.
- 0010 ADD/LDR/STR: r=val1+val2.
- 0011 ADC: r=val1+val2+Cin.
- 0100 SUB/CMP: r=val1-val2.
- 0101 SBC: r=val1-val2-(~Cin).
- 0110 AND/TST: r=val1&val2.
- 0111 ORR: r=val1|val2.
- 1000 EOR: r=val1^val2.
- Any other code: r=0. Flags unchanged even if `s_in`=1.

Flags computed on r:
- N=r[31]; Z=(r==0).
- ADD/ADC: C=carry-out of the 33-bit sum. V=(val1[31]==val2[31])&&(r[31]!=val1[31]).
- SUB/SBC: C=1 when there is no borrow (val1 ≥ val2+borrow, unsigned). V=(val1[31]!=val2[31])&&(r[31]!=val1[31]).
- Logical, MOV, MVN: C and V keep their old values. Only N and Z update.

Register update per rising edge, in priority order:
1. `rst_n`=0: `status`=0, `valid_out`=0, `alu_result`=0, `st_val`=0, `dest`=0, all control outputs 0.
2. `freeze`=1: every register holds, including `status`. `flush` is ignored this cycle.
3. `flush`=1 or `valid_in`=0: `valid_out`=0; `wb_en`, `mem_r_en`, `mem_w_en` = 0; `status` unchanged. Data outputs may take any value.
4. Otherwise: load r, `st_val_in`, `dest_in` and the controls; `valid_out`=1. If `s_in`=1, `status`={N,Z,C,V}.

## Timing
- Result latency is 1 cycle: inputs sampled at edge k appear on outputs after edge k.
- Flags written at edge k are visible as `Cin` to the instruction sampled at edge k+1. Back-to-back ADDS then ADC therefore chain correctly with no bubble.
- The ALU and flag logic are combinational from the inputs plus `status`. There is no combinational path from inputs to outputs.
- Reset during a freeze: reset wins.
- Simultaneous flush and `s_in`: flags are not updated.
- While `freeze`=1, `Cin` stays stable, so the held inputs re-evaluate identically.

## Test plan
- Reset: hold `rst_n`=0 two cycles with `valid_in`=1 and ADDS inputs. Required: all outputs 0, `status`=0000.
- ADDS 0xFFFFFFFF+1 (cmd 0010, s=1). Required: `alu_result`=0, `status`=0110 (Z,C). Next cycle ADC 5+7 with s=0. Required: result 13.
- SUBS 0x80000000-1. Required: result 0x7FFFFFFF, `status`=0011 (C,V). Then SBC 10-3 with s=0. Required: 7. Repeat SBC with C=0. Required: 6.
- ANDS 0xF0F0F0F0 & 0x0F0F0F0F with prior `status`=0011. Required: result 0, `status`=0111 (C and V preserved).
- Freeze: assert `freeze` for 3 cycles mid-stream with changing inputs. Required: outputs and `status` constant. After release, the pending instruction completes exactly once.
- Flush: CMPS 5-5 with `flush`=1. Required: `valid_out`=0, `wb_en`=0, `mem_w_en`=0, `status` unchanged. Same instruction without flush: `status`=0110.
